// File: rtl/crc8_arb_pkg.sv
// Shared types and CRC8 constants for the CRC8 share arbiter, its engine and models.
package crc8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_CRC,
    RELEASE
  } arb_state_t;

  // CRC8 definition used by the shared engine: MSB-first, no reflection, no final xor.
  localparam logic [7:0] CRC8_SEED = 8'h0D;
  localparam logic [7:0] CRC8_POLY = 8'hC6;

endpackage

// File: rtl/crc8_share_arbiter_if.sv
// Requester and engine signal bundle of the CRC8 share arbiter.
// master: the arbiter; slave: the requesters plus the CRC8 engine.
interface crc8_share_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int DATA_LENGTH = 32
);

  // Requester side
  logic [N_REQ-1:0]             req;
  logic [N_REQ*DATA_LENGTH-1:0] req_data;
  logic [N_REQ-1:0]             grant;
  logic [N_REQ-1:0]             done;
  logic [7:0]                   crc_result;
  logic                         crc_err;

  // Engine side
  logic [DATA_LENGTH-1:0]       crc_data;
  logic                         crc_valid;
  logic                         crc_clear;
  logic                         crc_ready;
  logic [7:0]                   crc8_in;

  modport master (
    input  req, req_data, crc_ready, crc8_in,
    output grant, done, crc_result, crc_err, crc_data, crc_valid, crc_clear
  );

  modport slave (
    output req, req_data, crc_ready, crc8_in,
    input  grant, done, crc_result, crc_err, crc_data, crc_valid, crc_clear
  );

endinterface

// File: rtl/crc8_share_arbiter_rr_pick.sv
// Round-robin picker: first set request scanning upward from i_ptr, wrapping at N_REQ-1.
module rr_pick #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic                     o_found,
  output logic [$clog2(N_REQ)-1:0] o_idx
);

  localparam int IDXW = $clog2(N_REQ);

  // Scan candidates ptr, ptr+1, ... modulo N_REQ; the first hit wins.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      int unsigned c;
      c = int'(i_ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!o_found && i_req[c]) begin
        o_found = 1'b1;
        o_idx   = IDXW'(c);
      end
    end
  end

endmodule

// File: rtl/crc8_share_arbiter.sv
// Round-robin sequencer sharing one CRC8 engine between N_REQ requesters.
// IDLE -> LAUNCH -> WAIT_CRC -> RELEASE -> IDLE, all outputs registered,
// with a watchdog that aborts a transaction when the engine never becomes ready.
module crc8_share_arbiter
  import crc8_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int DATA_LENGTH    = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 busy,
  crc8_share_arbiter_if.master bus
);

  localparam int IDXW = $clog2(N_REQ);
  localparam int CNTW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  arb_state_t             r_state, w_state_nxt;
  logic [IDXW-1:0]        r_idx, w_idx_nxt;
  logic [IDXW-1:0]        r_ptr, w_ptr_nxt;
  logic [CNTW-1:0]        r_count, w_count_nxt, w_count_inc;
  logic [N_REQ-1:0]       r_grant, w_grant_nxt;
  logic [N_REQ-1:0]       r_done, w_done_nxt;
  logic [7:0]             r_result, w_result_nxt;
  logic                   r_err, w_err_nxt;
  logic                   r_busy, w_busy_nxt;
  logic [DATA_LENGTH-1:0] r_data, w_data_nxt;
  logic                   r_valid, w_valid_nxt;
  logic                   r_clear, w_clear_nxt;

  logic                   w_found;
  logic [IDXW-1:0]        w_pick;
  logic [DATA_LENGTH-1:0] w_word;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_found (w_found),
    .o_idx   (w_pick)
  );

  // Select the data word of the requester the picker chose.
  always_comb begin
    w_word = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (w_pick == IDXW'(i)) w_word = bus.req_data[i*DATA_LENGTH +: DATA_LENGTH];
    end
  end

  // Next-state and next-output logic; every output is a register loaded from here.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_ptr_nxt    = r_ptr;
    w_count_nxt  = r_count;
    w_count_inc  = r_count + 1'b1;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_result_nxt = r_result;
    w_err_nxt    = 1'b0;
    w_busy_nxt   = r_busy;
    w_data_nxt   = r_data;
    w_valid_nxt  = 1'b0;
    w_clear_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_idx_nxt   = w_pick;
          w_data_nxt  = w_word;
          w_grant_nxt = ONE << w_pick;
          w_busy_nxt  = 1'b1;
          w_valid_nxt = 1'b1;
          w_state_nxt = LAUNCH;
        end
      end
      LAUNCH: begin
        w_count_nxt = '0;
        w_state_nxt = WAIT_CRC;
      end
      WAIT_CRC: begin
        // Abort is decided on the incremented count; ready in that same cycle still wins.
        if (bus.crc_ready) begin
          w_result_nxt = bus.crc8_in;
          w_done_nxt   = ONE << r_idx;
          w_clear_nxt  = 1'b1;
          w_state_nxt  = RELEASE;
        end else if (w_count_inc == CNTW'(TIMEOUT_CYCLES - 1)) begin
          w_err_nxt   = 1'b1;
          w_done_nxt  = ONE << r_idx;
          w_clear_nxt = 1'b1;
          w_state_nxt = RELEASE;
        end else begin
          w_count_nxt = w_count_inc;
        end
      end
      RELEASE: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_ptr_nxt   = (r_idx == IDXW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; asynchronous reset drops everything to zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_ptr    <= '0;
      r_count  <= '0;
      r_grant  <= '0;
      r_done   <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_clear  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_count  <= w_count_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= w_busy_nxt;
      r_data   <= w_data_nxt;
      r_valid  <= w_valid_nxt;
      r_clear  <= w_clear_nxt;
    end
  end

  assign busy           = r_busy;
  assign bus.grant      = r_grant;
  assign bus.done       = r_done;
  assign bus.crc_result = r_result;
  assign bus.crc_err    = r_err;
  assign bus.crc_data   = r_data;
  assign bus.crc_valid  = r_valid;
  assign bus.crc_clear  = r_clear;

endmodule

// File: tb/tb_crc8_share_arbiter.sv
// Bench for crc8_share_arbiter: byte-wise CRC8 engine, bit-serial CRC model and a
// modulo round-robin model of which requester should be served next.
module tb_crc8_share_arbiter;
  import crc8_arb_pkg::*;

  localparam int N  = 4;
  localparam int DL = 32;
  localparam int TO = 64;
  localparam int NB = DL / 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  logic busy;
  logic stuck   = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_valid = 0, n_clear = 0, n_done = 0, t_valid = 0, t_done = 0;

  int         m_ptr  = 0;
  logic [7:0] m_last = '0;
  logic [DL-1:0] words [N];

  crc8_share_arbiter_if #(.N_REQ(N), .DATA_LENGTH(DL)) bus ();

  crc8_share_arbiter #(
    .N_REQ          (N),
    .DATA_LENGTH    (DL),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .busy    (busy),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference CRC: one message bit at a time, MSB first.
  function automatic logic [7:0] crc_model(input logic [DL-1:0] w);
    logic [7:0] c;
    logic fb;
    c = CRC8_SEED;
    for (int i = DL - 1; i >= 0; i--) begin
      fb = c[7] ^ w[i];
      c  = {c[6:0], 1'b0};
      if (fb) c = c ^ CRC8_POLY;
    end
    return c;
  endfunction

  // Engine arithmetic: one byte per cycle.
  function automatic logic [7:0] byte_step(input logic [7:0] c_in, input logic [7:0] b);
    logic [7:0] c;
    c = c_in ^ b;
    for (int i = 0; i < 8; i++) c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
    return c;
  endfunction

  // Next requester to be served: first pending index at or after ptr, modulo N.
  function automatic int rr_next(input logic [N-1:0] pend, input int ptr);
    for (int k = 0; k < N; k++) if (pend[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // CRC8 engine: latch on valid, NB byte cycles, ready held until clear. stuck = never ready.
  logic [DL-1:0] e_word;
  logic [7:0]    e_crc;
  int            e_cnt;
  logic          e_busy;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      e_busy <= 1'b0; e_cnt <= 0; e_word <= '0; e_crc <= '0;
      bus.crc_ready <= 1'b0; bus.crc8_in <= '0;
    end else if (bus.crc_ready) begin
      if (bus.crc_clear) bus.crc_ready <= 1'b0;
    end else if (e_busy) begin
      e_crc  <= byte_step(e_crc, e_word[DL-1 -: 8]);
      e_word <= e_word << 8;
      e_cnt  <= e_cnt + 1;
      if (e_cnt == NB - 1) begin
        e_busy <= 1'b0;
        if (!stuck) begin
          bus.crc_ready <= 1'b1;
          bus.crc8_in   <= byte_step(e_crc, e_word[DL-1 -: 8]);
        end
      end
    end else if (bus.crc_valid) begin
      e_word <= bus.crc_data; e_crc <= CRC8_SEED; e_cnt <= 0; e_busy <= 1'b1;
    end
  end

  // Event counters sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.crc_valid) begin n_valid++; t_valid = cyc; end
    if (bus.crc_clear) n_clear++;
    if (bus.done != '0) begin n_done++; t_done = cyc; end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [DL-1:0] w);
    words[i] = w;
    bus.req_data[i*DL +: DL] = w;
  endtask

  task automatic do_reset();
    bus.req = '0;
    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    m_ptr  = 0;
    m_last = '0;
  endtask

  task automatic wait_done(output logic [N-1:0] d);
    int n;
    n = 0;
    do begin tick(); n++; end while (bus.done == '0 && n < 300);
    d = bus.done;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.req_data = '0; stuck = 1'b0;
    #1 reset_n = 1'b0;
    tick();
    checks++;
    if ({bus.grant, bus.done, busy, bus.crc_err} !== '0) begin
      errors++; $display("FAIL reset_ctl: got grant=%b done=%b busy=%b err=%b required 0",
                         bus.grant, bus.done, busy, bus.crc_err);
    end
    checks++;
    if ({bus.crc_valid, bus.crc_clear, bus.crc_data, bus.crc_result} !== '0) begin
      errors++; $display("FAIL reset_data: got valid=%b clear=%b data=%h result=%h required 0",
                         bus.crc_valid, bus.crc_clear, bus.crc_data, bus.crc_result);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || bus.crc_valid !== 1'b0) begin
      errors++; $display("FAIL idle_no_req: got busy=%b valid=%b required 0 0", busy, bus.crc_valid);
    end
  endtask

  task automatic test_single();
    logic [N-1:0] d;
    int v0, c0, d0;
    v0 = n_valid; c0 = n_clear; d0 = n_done;
    set_word(0, 32'h0000_0000);
    bus.req = 4'b0001;
    wait_done(d);
    checks++;
    if (d !== 4'b0001 || bus.crc_err !== 1'b0) begin
      errors++; $display("FAIL single_done: got done=%b err=%b required 0001 0", d, bus.crc_err);
    end
    checks++;
    if (bus.crc_result !== crc_model(words[0])) begin
      errors++; $display("FAIL single_crc: got %h required %h", bus.crc_result, crc_model(words[0]));
    end
    checks++;
    if (bus.grant !== 4'b0001) begin
      errors++; $display("FAIL single_grant: got %b required 0001", bus.grant);
    end
    checks++;
    if (t_done - t_valid !== NB + 2) begin
      errors++; $display("FAIL single_latency: got %0d required %0d", t_done - t_valid, NB + 2);
    end
    m_last = crc_model(words[0]); m_ptr = 1;
    bus.req = '0;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || bus.grant !== '0) begin
      errors++; $display("FAIL single_release: got busy=%b grant=%b required 0", busy, bus.grant);
    end
    checks++;
    if (n_valid - v0 !== 1 || n_clear - c0 !== 1 || n_done - d0 !== 1) begin
      errors++; $display("FAIL single_pulses: got valid=%0d clear=%0d done=%0d required 1 1 1",
                         n_valid - v0, n_clear - c0, n_done - d0);
    end
  endtask

  task automatic test_rotation();
    logic [N-1:0] d;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset();
    for (int i = 0; i < N; i++) set_word(i, 32'h1111_1111 * (i + 1));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done(d);
      checks++;
      if (d !== N'(1) << order[k]) begin
        errors++; $display("FAIL rot_order[%0d]: got %b required %b", k, d, N'(1) << order[k]);
      end
      checks++;
      if (bus.crc_result !== crc_model(words[order[k]])) begin
        errors++; $display("FAIL rot_crc[%0d]: got %h required %h", k, bus.crc_result,
                           crc_model(words[order[k]]));
      end
      m_last = crc_model(words[order[k]]);
      m_ptr  = (order[k] + 1) % N;
    end
    bus.req = '0;
    repeat (3) tick();
  endtask

  task automatic test_rr_ptr();
    logic [N-1:0] d;
    do_reset();
    set_word(1, $urandom());
    bus.req = 4'b0010;
    wait_done(d);
    bus.req = '0;
    checks++;
    if (d !== 4'b0010) begin errors++; $display("FAIL ptr_setup: got %b required 0010", d); end
    set_word(0, $urandom()); set_word(1, $urandom());
    bus.req = 4'b0011;
    wait_done(d);
    bus.req[0] = 1'b0;
    checks++;
    if (d !== 4'b0001 || bus.crc_result !== crc_model(words[0])) begin
      errors++; $display("FAIL ptr_wrap_first: got %b/%h required 0001/%h", d, bus.crc_result,
                         crc_model(words[0]));
    end
    wait_done(d);
    bus.req = '0;
    checks++;
    if (d !== 4'b0010 || bus.crc_result !== crc_model(words[1])) begin
      errors++; $display("FAIL ptr_wrap_second: got %b/%h required 0010/%h", d, bus.crc_result,
                         crc_model(words[1]));
    end
    set_word(3, $urandom());
    bus.req = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      wait_done(d);
      checks++;
      if (d !== 4'b1000 || bus.crc_result !== crc_model(words[3])) begin
        errors++; $display("FAIL alone_b2b[%0d]: got %b/%h required 1000/%h", k, d,
                           bus.crc_result, crc_model(words[3]));
      end
    end
    bus.req = '0;
    m_last = crc_model(words[3]); m_ptr = 0;
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    logic [N-1:0] d;
    int c0;
    c0 = n_clear;
    stuck = 1'b1;
    set_word(2, $urandom());
    bus.req = 4'b0100;
    wait_done(d);
    bus.req = '0;
    checks++;
    if (d !== 4'b0100 || bus.crc_err !== 1'b1) begin
      errors++; $display("FAIL to_done: got done=%b err=%b required 0100 1", d, bus.crc_err);
    end
    checks++;
    if (bus.crc_result !== m_last) begin
      errors++; $display("FAIL to_result_held: got %h required %h", bus.crc_result, m_last);
    end
    checks++;
    if (t_done - t_valid !== TO) begin
      errors++; $display("FAIL to_cycles: got %0d required %0d", t_done - t_valid, TO);
    end
    tick();
    checks++;
    if (bus.crc_err !== 1'b0 || bus.done !== '0) begin
      errors++; $display("FAIL to_pulse: got err=%b done=%b required 0", bus.crc_err, bus.done);
    end
    stuck = 1'b0;
    repeat (3) tick();
    checks++;
    if (n_clear - c0 !== 1) begin
      errors++; $display("FAIL to_clear: got %0d required 1", n_clear - c0);
    end
    m_ptr = 3;
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d;
    int d0, n;
    set_word(0, $urandom());
    bus.req = 4'b0001;
    n = 0;
    while (bus.crc_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.crc_valid !== 1'b1) begin errors++; $display("FAIL mid_launch: got 0 required 1"); end
    repeat (2) tick();
    d0 = n_done;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.grant, busy, bus.done, bus.crc_err, bus.crc_clear, bus.crc_data, bus.crc_result} !== '0) begin
      errors++; $display("FAIL mid_reset: got grant=%b busy=%b data=%h result=%h required 0",
                         bus.grant, busy, bus.crc_data, bus.crc_result);
    end
    bus.req = '0;
    tick();
    reset_n = 1'b1;
    m_ptr = 0; m_last = '0;
    repeat (2) tick();
    checks++;
    if (n_done !== d0) begin errors++; $display("FAIL mid_no_done: got %0d required %0d", n_done, d0); end
    set_word(1, $urandom());
    bus.req = 4'b0010;
    wait_done(d);
    bus.req = '0;
    checks++;
    if (d !== 4'b0010 || bus.crc_result !== crc_model(words[1])) begin
      errors++; $display("FAIL mid_after: got %b/%h required 0010/%h", d, bus.crc_result,
                         crc_model(words[1]));
    end
    m_last = crc_model(words[1]); m_ptr = 2;
    tick();
  endtask

  task automatic test_change_data();
    logic [N-1:0] d;
    logic [DL-1:0] a;
    int n;
    a = $urandom();
    set_word(3, a);
    bus.req = 4'b1000;
    n = 0;
    while (bus.grant === '0 && n < 20) begin tick(); n++; end
    bus.req_data[3*DL +: DL] = ~a;
    bus.req = '0;
    wait_done(d);
    checks++;
    if (d !== 4'b1000 || bus.crc_result !== crc_model(a)) begin
      errors++; $display("FAIL chg_crc: got %b/%h required 1000/%h", d, bus.crc_result, crc_model(a));
    end
    checks++;
    if (bus.crc_data !== a) begin
      errors++; $display("FAIL chg_data_stable: got %h required %h", bus.crc_data, a);
    end
    m_last = crc_model(a); m_ptr = 0;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [N-1:0] d, pend;
    int exp;
    for (int r = 0; r < 8; r++) begin
      pend = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) set_word(i, $urandom());
      bus.req = pend;
      while (pend != '0) begin
        exp = rr_next(pend, m_ptr);
        wait_done(d);
        checks++;
        if (d !== N'(1) << exp || bus.crc_result !== crc_model(words[exp])) begin
          errors++; $display("FAIL rand[%0d]: got %b/%h required %b/%h", r, d, bus.crc_result,
                             N'(1) << exp, crc_model(words[exp]));
        end
        if (d === '0) pend = '0;
        bus.req[exp] = 1'b0;
        pend[exp]    = 1'b0;
        m_ptr  = (exp + 1) % N;
        m_last = crc_model(words[exp]);
      end
      bus.req = '0;
      repeat ($urandom_range(1, 3)) tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_rr_ptr();
    test_timeout();
    test_reset_mid();
    test_change_data();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
